// File: rtl/tradeoff_isqrt_if.sv
// ============================================================================
// Module      : tradeoff_isqrt_if
// Description : Request/result bundle for the integer square-root engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tradeoff_isqrt_if #(
  parameter int N_BITS = 12
);
  logic                start;
  logic [1:0]          mode;
  logic [2*N_BITS:0]   W;
  logic                ready;
  logic                busy;
  logic                found;
  logic [N_BITS:0]     N;
  logic [N_BITS:0]     cycles;

  modport master (
    output start, mode, W,
    input  ready, busy, found, N, cycles
  );

  modport slave (
    input  start, mode, W,
    output ready, busy, found, N, cycles
  );
endinterface

`default_nettype wire

// File: rtl/tradeoff_isqrt.sv
// ============================================================================
// Module      : tradeoff_isqrt
// Description : floor(sqrt(W)) by binary, linear or hybrid search, selected
//               per request, with a per-run latency counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tradeoff_isqrt #(
  parameter int N_BITS   = 12,
  parameter int LIN_BITS = 4
) (
  input  wire                 clk,
  input  wire                 rst_n,
  tradeoff_isqrt_if.slave     bus
);

  localparam int KW = $clog2(N_BITS + 1);
  localparam logic [KW-1:0]     c_k_top  = KW'(N_BITS);
  localparam logic [KW-1:0]     c_lin_k  = KW'(LIN_BITS);
  localparam logic [KW-1:0]     c_k_one  = KW'(1);
  localparam logic [N_BITS:0]   c_one    = (N_BITS+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIN  = 2'd1,
    LIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [2*N_BITS:0]   r_w;
  logic [1:0]          r_mode;
  logic [N_BITS:0]     r_c;
  logic [KW-1:0]       r_k;
  logic [N_BITS:0]     r_cnt;
  logic [N_BITS:0]     r_n;
  logic [N_BITS:0]     r_cycles;
  logic                r_found;

  logic                w_hybrid;
  logic [KW-1:0]       w_stop;
  logic [N_BITS:0]     w_t;
  logic [N_BITS:0]     w_c1;
  logic [2*N_BITS+1:0] w_t_sq;
  logic [2*N_BITS+1:0] w_c1_sq;
  logic [2*N_BITS+1:0] w_w_ext;
  logic                w_t_fits;
  logic                w_c1_fits;
  logic [N_BITS:0]     w_cnt_inc;

  // Squares are formed at full double width so the compare never wraps.
  always_comb begin
    w_hybrid  = (r_mode == 2'd2);
    w_stop    = w_hybrid ? c_lin_k : '0;
    w_t       = r_c | (c_one << r_k);
    w_c1      = r_c + c_one;
    w_t_sq    = {{(N_BITS+1){1'b0}}, w_t}  * {{(N_BITS+1){1'b0}}, w_t};
    w_c1_sq   = {{(N_BITS+1){1'b0}}, w_c1} * {{(N_BITS+1){1'b0}}, w_c1};
    w_w_ext   = {1'b0, r_w};
    w_t_fits  = (w_t_sq <= w_w_ext);
    w_c1_fits = (w_c1_sq <= w_w_ext);
    w_cnt_inc = r_cnt + c_one;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_w      <= '0;
      r_mode   <= '0;
      r_c      <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_n      <= '0;
      r_cycles <= '0;
      r_found  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_w     <= bus.W;
            r_mode  <= bus.mode;
            r_c     <= '0;
            r_cnt   <= '0;
            r_k     <= c_k_top;
            r_found <= 1'b0;
            r_state <= (bus.mode == 2'd1) ? LIN : BIN;
          end
        end
        BIN: begin
          r_cnt <= w_cnt_inc;
          if (w_t_fits) r_c <= w_t;
          if (r_k == w_stop) begin
            if (w_hybrid) begin
              r_state <= LIN;
            end else begin
              r_state  <= DONE;
              r_found  <= 1'b1;
              r_n      <= w_t_fits ? w_t : r_c;
              r_cycles <= w_cnt_inc;
            end
          end else begin
            r_k <= r_k - c_k_one;
          end
        end
        LIN: begin
          r_cnt <= w_cnt_inc;
          if (w_c1_fits) begin
            r_c <= w_c1;
          end else begin
            // The failing check still costs an edge, hence the increment.
            r_state  <= DONE;
            r_found  <= 1'b1;
            r_n      <= r_c;
            r_cycles <= w_cnt_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready  = (r_state == IDLE) || (r_state == DONE);
  assign bus.busy   = (r_state == BIN)  || (r_state == LIN);
  assign bus.found  = r_found;
  assign bus.N      = r_n;
  assign bus.cycles = r_cycles;

endmodule

`default_nettype wire

// File: tb/tb_tradeoff_isqrt.sv
// ============================================================================
// Module      : tb_tradeoff_isqrt
// Description : Directed vector bench for tradeoff_isqrt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tradeoff_isqrt;

  localparam int N_BITS   = 12;
  localparam int LIN_BITS = 4;
  localparam int BUDGET   = 200;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tradeoff_isqrt_if #(.N_BITS(N_BITS)) bus ();

  tradeoff_isqrt #(.N_BITS(N_BITS), .LIN_BITS(LIN_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    int unsigned w;
    int unsigned n;
    int unsigned cyc;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start on a negedge; returns just after the accept edge.
  task automatic accept(input logic [1:0] m, input int unsigned w);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.W     = w[2*N_BITS:0];
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after the accept edge until found is seen high.
  task automatic wait_found(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.found && lat < BUDGET);
    if (!bus.found) chk("timeout_found", 0, 1);
  endtask

  initial begin
    int lat;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.W     = '0;
    checks    = 0;
    errors    = 0;

    vecs[0]  = '{2'd0, 32'd16777215, 4095, 13};
    vecs[1]  = '{2'd0, 32'd33554431, 5792, 13};
    vecs[2]  = '{2'd0, 32'd0,        0,    13};
    vecs[3]  = '{2'd1, 32'd0,        0,    1};
    vecs[4]  = '{2'd1, 32'd99,       9,    10};
    vecs[5]  = '{2'd1, 32'd100,      10,   11};
    vecs[6]  = '{2'd2, 32'd16777215, 4095, 25};
    vecs[7]  = '{2'd2, 32'd16777216, 4096, 10};
    vecs[8]  = '{2'd3, 32'd16777215, 4095, 13};
    vecs[9]  = '{2'd2, 32'd1000,     31,   25};
    vecs[10] = '{2'd2, 32'd256,      16,   10};
    vecs[11] = '{2'd1, 32'd1,        1,    2};
    vecs[12] = '{2'd0, 32'd1,        1,    13};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  32'(bus.ready),  1);
    chk("rst_busy",   32'(bus.busy),   0);
    chk("rst_found",  32'(bus.found),  0);
    chk("rst_N",      32'(bus.N),      0);
    chk("rst_cycles", 32'(bus.cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      accept(vecs[i].mode, vecs[i].w);
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 1);
      wait_found(lat);
      chk($sformatf("v%0d_N", i),      32'(bus.N),      vecs[i].n);
      chk($sformatf("v%0d_cycles", i), 32'(bus.cycles), vecs[i].cyc);
      chk($sformatf("v%0d_latency", i), lat,            vecs[i].cyc);
    end

    // start pulsed on edges 3 and 7 of a busy run, with W changed.
    accept(2'd0, 32'd16777215);
    lat = 0;
    do begin
      if (lat == 2 || lat == 6) begin
        bus.start = 1'b1;
        bus.W     = '0;
        bus.mode  = 2'd1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
    end while (!bus.found && lat < BUDGET);
    chk("ign_found",   32'(bus.found),  1);
    chk("ign_N",       32'(bus.N),      4095);
    chk("ign_cycles",  32'(bus.cycles), 13);
    chk("ign_latency", lat,             13);

    // Asynchronous reset mid-run clears everything at once.
    accept(2'd0, 32'd5000);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",  32'(bus.ready),  1);
    chk("mid_rst_busy",   32'(bus.busy),   0);
    chk("mid_rst_found",  32'(bus.found),  0);
    chk("mid_rst_N",      32'(bus.N),      0);
    chk("mid_rst_cycles", 32'(bus.cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'd1;
    bus.W     = 25'd1;
    @(posedge clk);
    #1;
    bus.W = 25'd3;
    wait_found(lat);
    chk("b2b1_N",       32'(bus.N),      1);
    chk("b2b1_cycles",  32'(bus.cycles), 2);
    chk("b2b1_latency", lat,             2);
    @(posedge clk);
    #1;
    chk("b2b2_found_drop", 32'(bus.found), 0);
    chk("b2b2_busy",       32'(bus.busy),  1);
    bus.start = 1'b0;
    wait_found(lat);
    chk("b2b2_N",       32'(bus.N),      1);
    chk("b2b2_cycles",  32'(bus.cycles), 2);
    chk("b2b2_latency", lat,             2);
    chk("b2b2_ready",   32'(bus.ready),  1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
